cgra_pe: RTL and testbench
==========================

// Module: cgra_pe
// PURPOSE
//  Parametrised second-generation CGRA processing element: WIDTH-bit datapath, N_NBR neighbour inputs,
//  N_REGS-entry local register file with result write-back, valid/ready data and config handshakes,
//  2-stage pipeline. Tiles in the CGRA array; fed by neighbour PEs and the array config loader.
// PARAMETERS
//  WIDTH   8  datapath width in bits (>=4, power of 2)
//  N_NBR   4  number of neighbour PE inputs
//  N_REGS  4  local register file entries (>=2, power of 2)
//  derived: SEL_W=$clog2(1+N_NBR+N_REGS), RIDX_W=$clog2(N_REGS), SH_W=$clog2(WIDTH)
// PORTS
//  clock      in   1              single clock, rising edge
//  reset      in   1              synchronous, active-high
//  en         in   1              global stall; 0 freezes all state (reset still wins)
//  cfg_in     in   CFG_W          {op[2:0], sel0[SEL_W], sel1[SEL_W], wb_en, wb_idx[RIDX_W]}
//  cfg_valid  in   1              config word offered
//  cfg_ready  out  1              config slot free
//  in_op_0    in   WIDTH          external operand 0 (source index 0 for sel0)
//  in_op_1    in   WIDTH          external operand 1 (source index 0 for sel1)
//  nbr_in     in   N_NBR*WIDTH    neighbour outputs, nbr i at [i*WIDTH +: WIDTH]
//  in_valid   in   1              operands valid this cycle
//  in_ready   out  1              PE accepts operands
//  out        out  WIDTH          registered ALU result
//  out_valid  out  1              out holds a new result this cycle
// BEHAVIOUR
//  Reset: active cfg=0 (OR, sel 0/0, no write-back), shadow empty, regfile=0, out=0, out_valid=0,
//   state RUN, cfg_ready=1, in_ready=1.
//  Source select: 0 = in_op_x; 1..N_NBR = nbr_in[sel-1]; N_NBR+1.. = reg[sel-N_NBR-1]; out of range -> 0.
//  Pipeline (en=1): S1 captures selected operands + v1<=in_valid&in_ready; S2 computes ALU,
//   out<=result, out_valid<=v1. Latency 2 edges accept->out_valid. Bubbles propagate as out_valid=0.
//  Write-back: when out_valid would go 1 and cfg.wb_en, reg[wb_idx]<=result on the same edge.
//   S1 read in that cycle sees the old value; no bypass.
//  ALU (mod 2^WIDTH): 000 OR, 001 AND, 010 XOR, 011 SHL by src1[SH_W-1:0], 100 ADD, 101 SUB (src0-src1),
//   110 SHR logical by src1[SH_W-1:0], 111 PASS src0 (see CONFIGURATION).
//  Config FSM: RUN, DRAIN.
//   RUN: cfg_ready=1, in_ready=1. cfg_valid&cfg_ready -> shadow<=cfg_in, go DRAIN.
//     Operand accepted in the same cycle uses the OLD config.
//   DRAIN: cfg_ready=0, in_ready=0. When v1=0 and no write-back pending: active<=shadow, go RUN
//     (takes effect on the next accepted operand).
//  en=0: no captures, no FSM moves, outputs hold, ready outputs still driven from state.
//  Reset mid-drain discards shadow; in-flight results lost, out_valid=0 next cycle.
// CONFIGURATION
//  CGRA_PE_MAC_EN defined: op 111 = MAC, acc<=acc+src0*src1 (truncated to WIDTH), out=new acc.
//   acc resets to 0 and clears to 0 on every config activation.
//  Undefined: op 111 = PASS src0; no acc register or multiplier synthesised.
// STRUCTURE
//  cgra_pkg: pe_op_e enum (3-bit opcodes), pe_cfg_t packed struct parametrised by SEL_W/RIDX_W,
//   pe_state_e {RUN, DRAIN}.
//  Sub-module pe_alu (combinational, WIDTH-parametrised, op decode + shifter).
//  Top holds muxes, pipeline regs, regfile, FSM.
// TESTING (WIDTH=8, N_NBR=4, N_REGS=4, SEL_W=4)
//  1 reset; cfg ADD sel0=0 sel1=0; in_op_0=0x7F, in_op_1=0x02, in_valid=1
//    -> out=0x81, out_valid=1 two edges after accept.
//  2 SUB nbr_in[1]=0x03 (sel0=2) minus in_op_1=0x05 -> out=0xFE. SHL 0x81 by 9 (masked to 1) -> 0x02.
//  3 cfg ADD wb_en=1 wb_idx=2, ops 1+1 -> reg[2]=0x02.
//    Next cfg sel0=7 (reg2) PASS -> out=0x02; back-to-back read during write -> old 0x00.
//  4 cfg_valid with in_valid in same cycle -> operand uses old op; cfg_ready=0, in_ready=0 for
//    2 cycles of drain; next operand uses new op.
//  5 en=0 for 3 cycles mid-pipe -> out/out_valid frozen; resume gives the same result one cycle later.
//    Reset during DRAIN -> cfg_ready=1, out_valid=0.
//  6 CGRA_PE_MAC_EN: op 111, pairs (2,3),(4,5) -> out 0x06 then 0x1A; new cfg -> acc=0.
//    Without the macro: op 111 with src0=0x5A -> 0x5A.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared types for the CGRA processing element: opcodes, config FSM states and
// the config word layout at the default geometry (SEL_W=4, RIDX_W=2).
package cgra_pkg;

    typedef enum logic [2:0] {
        OP_OR   = 3'b000,
        OP_AND  = 3'b001,
        OP_XOR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } pe_op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } pe_state_e;

    localparam int DEF_SEL_W  = 4;
    localparam int DEF_RIDX_W = 2;

    // The top re-declares this layout with its own SEL_W/RIDX_W; field order is fixed.
    typedef struct packed {
        pe_op_e                  op;
        logic [DEF_SEL_W-1:0]    sel0;
        logic [DEF_SEL_W-1:0]    sel1;
        logic                    wb_en;
        logic [DEF_RIDX_W-1:0]   wb_idx;
    } pe_cfg_t;

    function automatic int cfg_width(input int sel_w, input int ridx_w);
        return 3 + 2 * sel_w + 1 + ridx_w;
    endfunction

endpackage

// File: rtl/cgra_pe_alu.sv
// Combinational ALU for cgra_pe. With CGRA_PE_MAC_EN defined, op 111 is a
// multiply-accumulate on the supplied accumulator; otherwise it passes src0.
module pe_alu
    import cgra_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  pe_op_e           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef CGRA_PE_MAC_EN
    input  logic [WIDTH-1:0] acc_i,
`endif
    output logic [WIDTH-1:0] res_o
);
    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] sh;

    always_comb begin
        sh    = b_i[SH_W-1:0];
        res_o = '0;
        case (op_i)
            OP_OR:   res_o = a_i | b_i;
            OP_AND:  res_o = a_i & b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_SHL:  res_o = a_i << sh;
            OP_ADD:  res_o = a_i + b_i;
            OP_SUB:  res_o = a_i - b_i;
            OP_SHR:  res_o = a_i >> sh;
`ifdef CGRA_PE_MAC_EN
            OP_PASS: res_o = acc_i + a_i * b_i;
`else
            OP_PASS: res_o = a_i;
`endif
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/cgra_pe.sv
// CGRA processing element: operand select, 2-stage pipe, local regfile with
// write-back and a RUN/DRAIN config loader. Optional MAC via CGRA_PE_MAC_EN.
module cgra_pe
    import cgra_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int N_NBR  = 4,
    parameter  int N_REGS = 4,
    localparam int SEL_W  = $clog2(1 + N_NBR + N_REGS),
    localparam int RIDX_W = $clog2(N_REGS),
    localparam int CFG_W  = 3 + 2 * SEL_W + 1 + RIDX_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic [CFG_W-1:0]       cfg_in,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [WIDTH-1:0]       in_op_0,
    input  logic [WIDTH-1:0]       in_op_1,
    input  logic [N_NBR*WIDTH-1:0] nbr_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid
);
    typedef struct packed {
        pe_op_e              op;
        logic [SEL_W-1:0]    sel0;
        logic [SEL_W-1:0]    sel1;
        logic                wb_en;
        logic [RIDX_W-1:0]   wb_idx;
    } cfg_t;

    pe_state_e                     state_q, state_d;
    cfg_t                          active_q, active_d;
    cfg_t                          shadow_q, shadow_d;
    logic                          v1_q, v1_d;
    logic [WIDTH-1:0]              op0_q, op0_d, op1_q, op1_d;
    logic [WIDTH-1:0]              out_q, out_d;
    logic                          out_valid_q, out_valid_d;
    logic [N_REGS-1:0][WIDTH-1:0]  rf_q, rf_d;
    logic [WIDTH-1:0]              src0, src1, alu_res;
    logic                          accept;
`ifdef CGRA_PE_MAC_EN
    logic [WIDTH-1:0]              acc_q, acc_d;
`endif

    // 0 = external operand, then neighbours, then regfile; anything beyond reads 0.
    function automatic logic [WIDTH-1:0] pick_src(
        input logic [SEL_W-1:0]              sel,
        input logic [WIDTH-1:0]              ext,
        input logic [N_NBR*WIDTH-1:0]        nbr,
        input logic [N_REGS-1:0][WIDTH-1:0]  regs
    );
        logic [WIDTH-1:0] v;
        v = '0;
        if (sel == '0) v = ext;
        for (int i = 0; i < N_NBR; i++)
            if (int'(sel) == i + 1) v = nbr[i*WIDTH +: WIDTH];
        for (int r = 0; r < N_REGS; r++)
            if (int'(sel) == N_NBR + 1 + r) v = regs[r];
        return v;
    endfunction

    assign cfg_ready = (state_q == ST_RUN);
    assign in_ready  = (state_q == ST_RUN);
    assign accept    = in_valid & in_ready;
    assign src0      = pick_src(active_q.sel0, in_op_0, nbr_in, rf_q);
    assign src1      = pick_src(active_q.sel1, in_op_1, nbr_in, rf_q);
    assign out       = out_q;
    assign out_valid = out_valid_q;

    pe_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i  (active_q.op),
        .a_i   (op0_q),
        .b_i   (op1_q),
`ifdef CGRA_PE_MAC_EN
        .acc_i (acc_q),
`endif
        .res_o (alu_res)
    );

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        shadow_d    = shadow_q;
        v1_d        = v1_q;
        op0_d       = op0_q;
        op1_d       = op1_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        rf_d        = rf_q;
`ifdef CGRA_PE_MAC_EN
        acc_d       = acc_q;
`endif
        if (en) begin
            v1_d        = accept;
            out_valid_d = v1_q;
            if (accept) begin
                op0_d = src0;
                op1_d = src1;
            end
            // Write-back lands on the same edge S1 samples the regfile, so S1 sees the old value.
            if (v1_q) begin
                out_d = alu_res;
                if (active_q.wb_en) rf_d[active_q.wb_idx] = alu_res;
`ifdef CGRA_PE_MAC_EN
                if (active_q.op == OP_PASS) acc_d = alu_res;
`endif
            end
            case (state_q)
                ST_RUN: begin
                    if (cfg_valid) begin
                        shadow_d = cfg_t'(cfg_in);
                        state_d  = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // v1_q=0 means nothing in S1 and hence no write-back still to land.
                    if (!v1_q) begin
                        active_d = shadow_q;
                        state_d  = ST_RUN;
`ifdef CGRA_PE_MAC_EN
                        acc_d    = '0;
`endif
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            active_q    <= '0;
            shadow_q    <= '0;
            v1_q        <= 1'b0;
            op0_q       <= '0;
            op1_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            rf_q        <= '0;
`ifdef CGRA_PE_MAC_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            v1_q        <= v1_d;
            op0_q       <= op0_d;
            op1_q       <= op1_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            rf_q        <= rf_d;
`ifdef CGRA_PE_MAC_EN
            acc_q       <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_cgra_pe.sv
// Bench for cgra_pe: directed vector table, hand-written multi-cycle sequences and
// a randomized phase, all checked every cycle against a transaction-level model.
module tb_cgra_pe;
    localparam int WIDTH = 8, N_NBR = 4, N_REGS = 4, CFG_W = 14;

    logic                   clock = 1'b0;
    logic                   reset, en, cfg_valid, in_valid;
    logic [CFG_W-1:0]       cfg_in;
    logic [WIDTH-1:0]       in_op_0, in_op_1;
    logic [N_NBR*WIDTH-1:0] nbr_in;
    logic                   cfg_ready, in_ready, out_valid;
    logic [WIDTH-1:0]       out;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clock = ~clock;

    cgra_pe #(.WIDTH(WIDTH), .N_NBR(N_NBR), .N_REGS(N_REGS)) dut (
        .clock(clock), .reset(reset), .en(en), .cfg_in(cfg_in), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .in_op_0(in_op_0), .in_op_1(in_op_1), .nbr_in(nbr_in),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CFG_W-1:0] mk_cfg(input int op, input int s0, input int s1,
                                                input int wb, input int idx);
        return {3'(op), 4'(s0), 4'(s1), 1'(wb), 2'(idx)};
    endfunction

    // ---------------- reference model: one record per accepted operand pair ----------------
    typedef struct { logic [7:0] a; logic [7:0] b; logic [CFG_W-1:0] c; } flight_t;
    flight_t          flight[$];
    flight_t          m_new, m_old;
    logic [CFG_W-1:0] m_active, m_shadow;
    bit               m_drain, m_ov, m_took, m_was_drain;
    int               m_inflight;
    logic [7:0]       m_rf[N_REGS];
    logic [7:0]       m_acc, m_out, m_res;

    function automatic logic [7:0] ref_src(input int sel, input logic [7:0] ext);
        if (sel == 0) return ext;
        if (sel <= N_NBR) return nbr_in[(sel-1)*8 +: 8];
        if (sel <= N_NBR + N_REGS) return m_rf[sel-N_NBR-1];
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_alu(input int op, input logic [7:0] a, input logic [7:0] b);
        int x, ia, ib;
        ia = int'(a);
        ib = int'(b);
        case (op)
            0: x = ia | ib;
            1: x = ia & ib;
            2: x = ia ^ ib;
            3: x = ia * (1 << (ib % 8));
            4: x = ia + ib;
            5: x = ia - ib + 256;
            6: x = ia / (1 << (ib % 8));
`ifdef CGRA_PE_MAC_EN
            default: x = int'(m_acc) + ia * ib;
`else
            default: x = ia;
`endif
        endcase
        return 8'(x % 256);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            flight.delete();
            m_active = '0; m_shadow = '0; m_drain = 0; m_ov = 0;
            m_acc = 0; m_out = 0;
            for (int i = 0; i < N_REGS; i++) m_rf[i] = 8'h00;
        end else if (en) begin
            m_was_drain = m_drain;
            m_inflight  = flight.size();
            m_took      = in_valid && !m_was_drain;
            if (m_took) begin
                m_new.a = ref_src(int'(m_active[10:7]), in_op_0);
                m_new.b = ref_src(int'(m_active[6:3]), in_op_1);
                m_new.c = m_active;
            end
            m_ov = 0;
            if (m_inflight > 0) begin
                m_old = flight.pop_front();
                m_res = ref_alu(int'(m_old.c[13:11]), m_old.a, m_old.b);
                m_out = m_res;
                m_ov  = 1;
                if (m_old.c[2]) m_rf[int'(m_old.c[1:0])] = m_res;
                if (m_old.c[13:11] == 3'd7) m_acc = m_res;
            end
            if (m_took) flight.push_back(m_new);
            if (m_was_drain && m_inflight == 0) begin
                m_active = m_shadow; m_drain = 0; m_acc = 0;
            end else if (!m_was_drain && cfg_valid) begin
                m_shadow = cfg_in; m_drain = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("m_cfg_ready", cfg_ready, !m_drain);
            chk("m_in_ready", in_ready, !m_drain);
            chk("m_out_valid", out_valid, m_ov);
            if (m_ov) chk("m_out", out, m_out);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        reset = 1; en = 1; cfg_valid = 0; in_valid = 0;
        @(negedge clock); @(negedge clock);
        reset = 0;
    endtask

    task automatic wait_cfg_ready();
        int n = 0;
        while (!cfg_ready && n < 10) begin @(negedge clock); n++; end
        chk("cfg_ready_wait", cfg_ready, 1);
    endtask

    task automatic load_cfg(input logic [CFG_W-1:0] c);
        wait_cfg_ready();
        cfg_in = c; cfg_valid = 1;
        @(negedge clock);
        cfg_valid = 0;
        wait_cfg_ready();
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string name,
                          input logic [7:0] exp);
        in_op_0 = a; in_op_1 = b; in_valid = 1;
        @(negedge clock);
        in_valid = 0;
        @(negedge clock);
        chk({name, "_valid"}, out_valid, 1);
        chk(name, out, exp);
    endtask

    typedef struct {
        int op; int s0; int s1; logic [7:0] a; logic [7:0] b; logic [31:0] nbr; logic [7:0] exp;
    } vec_t;
    vec_t vecs[10];

    initial begin
        vecs[0] = '{4, 0, 0, 8'h7F, 8'h02, 32'h0,         8'h81}; // ADD carry into MSB
        vecs[1] = '{5, 2, 0, 8'h00, 8'h05, 32'h0000_0300, 8'hFE}; // nbr1 - op1 wraps
        vecs[2] = '{3, 0, 0, 8'h81, 8'h09, 32'h0,         8'h02}; // shift amount masked
        vecs[3] = '{0, 0, 0, 8'hF0, 8'h0F, 32'h0,         8'hFF};
        vecs[4] = '{1, 0, 0, 8'hF0, 8'h3C, 32'h0,         8'h30};
        vecs[5] = '{2, 0, 0, 8'hFF, 8'h0F, 32'h0,         8'hF0};
        vecs[6] = '{6, 0, 0, 8'h80, 8'h0F, 32'h0,         8'h01}; // logical right by 7
        vecs[7] = '{5, 0, 0, 8'h00, 8'h01, 32'h0,         8'hFF};
        vecs[8] = '{4, 12, 0, 8'hAA, 8'h33, 32'h0,        8'h33}; // out-of-range sel -> 0
        vecs[9] = '{4, 4, 1, 8'h00, 8'h00, 32'h1000_0020, 8'h30}; // nbr3 + nbr0

        cfg_in = '0; in_op_0 = '0; in_op_1 = '0; nbr_in = '0;
        do_reset();
        chk_on = 1;
        chk("rst_out", out, 8'h00);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            load_cfg(mk_cfg(vecs[i].op, vecs[i].s0, vecs[i].s1, 0, 0));
            nbr_in = vecs[i].nbr;
            run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), vecs[i].exp);
        end

        // regfile write-back, read-back, and no-bypass on back-to-back
        do_reset();
        load_cfg(mk_cfg(4, 0, 0, 1, 2));
        run_op(8'h01, 8'h01, "wb_add", 8'h02);
        load_cfg(mk_cfg(0, 7, 9, 0, 0));
        run_op(8'hEE, 8'hEE, "rd_reg2", 8'h02);
        load_cfg(mk_cfg(4, 8, 0, 1, 3));
        in_op_1 = 8'h05; in_valid = 1;
        @(negedge clock);
        in_op_1 = 8'h07;
        @(negedge clock);
        in_valid = 0;
        chk("b2b_first", out, 8'h05);
        @(negedge clock);
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second", out, 8'h07);
        load_cfg(mk_cfg(0, 8, 9, 0, 0));
        run_op(8'h00, 8'h00, "rd_reg3", 8'h07);

        // config handshake coincident with operand: old op used, 2-cycle drain
        load_cfg(mk_cfg(4, 0, 0, 0, 0));
        cfg_in = mk_cfg(5, 0, 0, 0, 0); cfg_valid = 1;
        in_op_0 = 8'h0A; in_op_1 = 8'h03; in_valid = 1;
        @(negedge clock);
        cfg_valid = 0;
        chk("drain1_cfg_ready", cfg_ready, 0);
        chk("drain1_in_ready", in_ready, 0);
        @(negedge clock);
        chk("drain2_in_ready", in_ready, 0);
        chk("old_op_out", out, 8'h0D);
        @(negedge clock);
        chk("post_drain_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 0;
        @(negedge clock);
        chk("new_op_valid", out_valid, 1);
        chk("new_op_out", out, 8'h07);

        // stall with a result on the output and another in S1
        load_cfg(mk_cfg(4, 0, 0, 0, 0));
        in_op_0 = 8'h01; in_op_1 = 8'h02; in_valid = 1;
        @(negedge clock);
        in_op_0 = 8'h04; in_op_1 = 8'h05;
        @(negedge clock);
        in_valid = 0; en = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("stall_valid", out_valid, 1);
            chk("stall_out", out, 8'h03);
        end
        en = 1;
        @(negedge clock);
        chk("resume_out", out, 8'h09);
        @(negedge clock);
        chk("resume_bubble", out_valid, 0);

        // reset in the middle of a drain drops the shadow config and the in-flight result
        load_cfg(mk_cfg(2, 0, 0, 0, 0));
        cfg_in = mk_cfg(1, 0, 0, 0, 0); cfg_valid = 1;
        in_op_0 = 8'h11; in_op_1 = 8'h22; in_valid = 1;
        @(negedge clock);
        cfg_valid = 0; in_valid = 0; reset = 1;
        @(negedge clock);
        reset = 0;
        chk("rstdrain_cfg_ready", cfg_ready, 1);
        chk("rstdrain_out_valid", out_valid, 0);
        run_op(8'hF0, 8'h0F, "rstdrain_cfg_is_or", 8'hFF);

`ifdef CGRA_PE_MAC_EN
        load_cfg(mk_cfg(7, 0, 0, 0, 0));
        run_op(8'h02, 8'h03, "mac1", 8'h06);
        run_op(8'h04, 8'h05, "mac2", 8'h1A);
        load_cfg(mk_cfg(7, 0, 0, 0, 0));
        run_op(8'h01, 8'h01, "mac_cleared", 8'h01);
`else
        load_cfg(mk_cfg(7, 0, 0, 0, 0));
        run_op(8'h5A, 8'hC3, "pass", 8'h5A);
`endif

        // randomized traffic; the per-cycle model check does the comparing
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 7) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_in    = CFG_W'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op_0   = 8'($urandom);
            in_op_1   = 8'($urandom);
            nbr_in    = $urandom;
            @(negedge clock);
        end
        reset = 0; cfg_valid = 0; in_valid = 0; en = 1;
        @(negedge clock); @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
